// File: rtl/bch_err_correct.sv
// rtl/bch_err_correct.sv - BCH codeword buffer and error correction behind the Chien search
// Holds one received word, replays it XORed with the Chien err strobe, and checks the error count against the locator degree.
module bch_err_correct #(
  parameter int N = 15,
  parameter int M = 4,
  parameter int T = 3,
  localparam int DW = $clog2(T + 1),
  localparam int CW = $clog2(N + 1),
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  input  logic          ch_start,
  input  logic [DW-1:0] err_deg,
  input  logic          cei,
  input  logic          err,
  output logic          out_valid,
  output logic          out_bit,
  output logic          out_last,
  output logic          done,
  output logic          uncorrectable,
  output logic [CW-1:0] err_count
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FULL    = 2'd1,
    CORRECT = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  // A shortened code cannot be longer than the field allows; nothing to build otherwise.
  if (N > (2 ** M) - 1) begin : g_length_exceeds_field
  end

  state_t          state, state_next;
  logic [N-1:0]    mem;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   deg_q;
  logic [CW-1:0]   cnt_next;
  logic            wr_last, rd_last;

  assign wr_last = (wr_ptr == PW'(N - 1));
  assign rd_last = (rd_ptr == PW'(N - 1));

  always_comb begin
    cnt_next = err_count;
    if (err && (err_count != CNT_MAX)) cnt_next = err_count + 1'b1;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_last) state_next = FULL;
      end
      FULL: begin
        if (ch_start) state_next = CORRECT;
      end
      CORRECT: begin
        if (cei && rd_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // The buffer is not reset; its contents are only read after a full reload.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) mem[wr_ptr] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      deg_q         <= '0;
      out_valid     <= 1'b0;
      out_bit       <= 1'b0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      uncorrectable <= 1'b0;
      err_count     <= '0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        end
        FULL: begin
          if (ch_start) begin
            deg_q     <= err_deg;
            err_count <= '0;
            rd_ptr    <= '0;
          end
        end
        CORRECT: begin
          if (cei) begin
            out_valid <= 1'b1;
            out_bit   <= mem[rd_ptr] ^ err;
            out_last  <= rd_last;
            err_count <= cnt_next;
            rd_ptr    <= rd_last ? '0 : rd_ptr + 1'b1;
            if (rd_last) begin
              done          <= 1'b1;
              uncorrectable <= (cnt_next != CW'(deg_q));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_err_correct.sv
// tb/tb_bch_err_correct.sv - self-checking bench for bch_err_correct
// Directed vector table plus random words checked against an XOR/popcount reference model.
module tb_bch_err_correct;
  localparam int N = 15;
  localparam int M = 4;
  localparam int T = 3;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, ch_start, cei, err;
  logic [1:0] err_deg;
  logic       in_ready, out_valid, out_bit, out_last, done, uncorrectable;
  logic [3:0] err_count;

  int checks = 0;
  int passed = 0;

  bch_err_correct #(.N(N), .M(M), .T(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .ch_start(ch_start), .err_deg(err_deg), .cei(cei), .err(err),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last), .done(done),
    .uncorrectable(uncorrectable), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] data;
    logic [14:0] errs;
    logic [1:0]  deg;
    int          gap;
    logic [14:0] exp_word;
    logic [3:0]  exp_cnt;
    logic        exp_unc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [14:0] data, input bit poke_start);
    chk("in_ready_load", in_ready, 1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_bit   = data[i];
      ch_start = poke_start && (i == 7);
      err_deg  = 2'd2;
      step();
    end
    ch_start = 1'b0;
    chk("in_ready_full", in_ready, 0);
    // stray input bit and cei while FULL must both be ignored
    in_valid = 1'b1;
    in_bit   = ~data[0];
    cei      = 1'b1;
    err      = 1'b1;
    step();
    in_valid = 1'b0;
    cei      = 1'b0;
    err      = 1'b0;
    chk("full_cei_ignored", out_valid, 0);
  endtask

  task automatic correct_word(input logic [14:0] errs, input logic [1:0] deg, input int gap,
                              output logic [14:0] word, output int nvalid, output int bad);
    word   = '0;
    nvalid = 0;
    bad    = 0;
    ch_start = 1'b1;
    err_deg  = deg;
    step();
    ch_start = 1'b0;
    err_deg  = ~deg;
    if (out_valid || done) bad++;
    for (int p = 0; p < N; p++) begin
      for (int g = 0; g < gap; g++) begin
        cei = 1'b0;
        err = 1'($urandom_range(1));
        step();
        if (out_valid || done) bad++;
      end
      cei = 1'b1;
      err = errs[p];
      step();
      cei = 1'b0;
      err = 1'b0;
      if (!out_valid || (out_last != (p == N - 1)) || (done != (p == N - 1))) bad++;
      if (out_valid) begin
        word[p] = out_bit;
        nvalid++;
      end
    end
  endtask

  task automatic run_word(input logic [14:0] data, input logic [14:0] errs, input logic [1:0] deg,
                          input int gap, input logic [14:0] exp_word, input logic [3:0] exp_cnt,
                          input logic exp_unc, input bit poke_start);
    logic [14:0] word;
    int nvalid, bad;
    load_word(data, poke_start);
    correct_word(errs, deg, gap, word, nvalid, bad);
    chk("word", word, exp_word);
    chk("valid_count", nvalid, N);
    chk("timing", bad, 0);
    chk("err_count", err_count, exp_cnt);
    chk("uncorrectable", uncorrectable, exp_unc);
    chk("in_ready_after_done", in_ready, 1);
    step();
    chk("done_pulse_end", {done, out_valid}, 0);
    chk("unc_held", uncorrectable, exp_unc);
  endtask

  initial begin
    logic [14:0] data, errs, ew;
    logic [3:0]  cnt;
    logic [1:0]  deg;
    int          bad;

    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; ch_start = 1'b0;
    cei = 1'b0; err = 1'b0; err_deg = 2'd0;
    step();
    step();
    reset = 1'b0;
    chk("reset_outputs", {out_valid, out_bit, out_last, done, uncorrectable, err_count}, 0);
    chk("reset_in_ready", in_ready, 1);

    vecs[0] = '{15'h5A3C, 15'h0000, 2'd0, 0, 15'h5A3C, 4'd0, 1'b0};
    vecs[1] = '{15'h5A3C, 15'h0020, 2'd1, 0, 15'h5A1C, 4'd1, 1'b0};
    vecs[2] = '{15'h5A3C, 15'h1284, 2'd3, 0, 15'h48B8, 4'd4, 1'b1};
    vecs[3] = '{15'h5A3C, 15'h0000, 2'd0, 2, 15'h5A3C, 4'd0, 1'b0};
    vecs[4] = '{15'h5A3C, 15'h0007, 2'd3, 1, 15'h5A3B, 4'd3, 1'b0};
    for (int v = 0; v < 5; v++)
      run_word(vecs[v].data, vecs[v].errs, vecs[v].deg, vecs[v].gap,
               vecs[v].exp_word, vecs[v].exp_cnt, vecs[v].exp_unc, 1'b0);

    // ch_start during LOAD is ignored; word left with uncorrectable=1 before the reset test
    run_word(15'h2B6D, 15'h4001, 2'd0, 0, 15'h2B6D ^ 15'h4001, 4'd2, 1'b1, 1'b1);
    load_word(15'h7F00, 1'b0);
    chk("err_count_held", err_count, 4'd2);
    ch_start = 1'b1; err_deg = 2'd0;
    step();
    ch_start = 1'b0;
    for (int p = 0; p < 8; p++) begin
      cei = 1'b1;
      err = (p == 3);
      step();
    end
    cei = 1'b1; err = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_outputs", {out_valid, out_bit, out_last, done, uncorrectable, err_count}, 0);
    chk("midreset_in_ready", in_ready, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid || done) bad++;
    end
    cei = 1'b0; err = 1'b0;
    chk("load_cei_ignored", bad, 0);
    run_word(15'h1357, 15'h0100, 2'd1, 1, 15'h1257, 4'd1, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      data = 15'($urandom);
      errs = '0;
      if (r == 7) errs = '1;
      else for (int k = $urandom_range(0, 5); k > 0; k--) errs[$urandom_range(0, N - 1)] = 1'b1;
      cnt = 4'($countones(errs));
      deg = 2'($urandom_range(0, 3));
      if ($urandom_range(1) == 1 && cnt <= 3) deg = 2'(cnt);
      ew = data ^ errs;
      run_word(data, errs, deg, $urandom_range(0, 3), ew, cnt, (32'(cnt) != 32'(deg)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
